// File: rtl/key_input_pkg.sv
// Shared key-input definitions: key code type, key count, capture FSM states and
// small helpers to count and encode debounced key levels.
package key_input_pkg;

    localparam int NUM_KEYS = 4;
    localparam int unsigned POP_W = 3;

    typedef logic [1:0] key_code_t;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        EMIT         = 2'd1,
        WAIT_RELEASE = 2'd2
    } kpc_state_t;

    // Number of keys currently held.
    function automatic logic [POP_W-1:0] key_popcount(input logic [NUM_KEYS-1:0] keys);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            n = n + POP_W'(keys[i]);
        end
        return n;
    endfunction

    // Index of the lowest held key; meaningful when exactly one key is held.
    function automatic key_code_t key_encode(input logic [NUM_KEYS-1:0] keys);
        key_code_t c;
        c = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (keys[i]) begin
                c = key_code_t'(i);
            end
        end
        return c;
    endfunction

endpackage : key_input_pkg

// File: rtl/key_debounce.sv
// One key channel: 2-FF synchroniser on the raw active-low button, inversion to
// active high, then a stability counter that only accepts a new level after it
// has been seen for DEBOUNCE_CYCLES consecutive cycles.
//   clk      system clock
//   rst      asynchronous active-high reset
//   key_raw  raw push button, active low, asynchronous to clk
//   held     debounced level, active high (1 = pressed)
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic held
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync_q1;
    logic             sync_q2;
    logic             pressed;
    logic [CNT_W-1:0] cnt;

    // Synchroniser resets to the released (high) level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
        end else begin
            sync_q1 <= key_raw;
            sync_q2 <= sync_q1;
        end
    end

    assign pressed = ~sync_q2;

    // Any cycle agreeing with the accepted level restarts the count, so short glitches vanish.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            held <= 1'b0;
        end else if (pressed == held) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            held <= pressed;
            cnt  <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule : key_debounce

// File: rtl/key_press_capture.sv
// Input stage for the Simon game core: debounces the four push buttons, turns a
// single new key press into one valid/ready event carrying its 2-bit code, and
// rejects chords with a one-cycle multi_press pulse.
// Optional feature macro KEY_PRESS_COUNT_EN adds press_count, a saturating count
// of accepted events.
//   clk          system clock
//   rst          asynchronous active-high reset
//   key          raw push buttons, active low
//   press_valid  event presented on press_code
//   press_code   index of pressed key
//   press_ready  consumer accepts event when press_valid && press_ready
//   key_held     debounced key levels, active high
//   multi_press  one-cycle pulse on a rejected chord
//   press_count  (KEY_PRESS_COUNT_EN only) accepted events, saturates at 255
module key_press_capture
    import key_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key,
    output logic                press_valid,
    output key_code_t           press_code,
    input  logic                press_ready,
    output logic [NUM_KEYS-1:0] key_held,
`ifdef KEY_PRESS_COUNT_EN
    output logic                multi_press,
    output logic [7:0]          press_count
`else
    output logic                multi_press
`endif
);

    kpc_state_t       state;
    logic [POP_W-1:0] held_count;
    logic [NUM_KEYS-1:0] held_vec;

    // One debounce channel per key.
    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .rst    (rst),
            .key_raw(key[g]),
            .held   (held_vec[g])
        );
    end

    assign key_held   = held_vec;
    assign held_count = key_popcount(held_vec);

    // Capture FSM: one event per press, held steady under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            press_valid <= 1'b0;
            press_code  <= '0;
            multi_press <= 1'b0;
        end else begin
            multi_press <= 1'b0;
            case (state)
                IDLE: begin
                    if (held_count == POP_W'(1)) begin
                        press_code  <= key_encode(held_vec);
                        press_valid <= 1'b1;
                        state       <= EMIT;
                    end else if (held_count >= POP_W'(2)) begin
                        multi_press <= 1'b1;
                        state       <= WAIT_RELEASE;
                    end
                end
                EMIT: begin
                    if (press_ready) begin
                        press_valid <= 1'b0;
                        state       <= WAIT_RELEASE;
                    end
                end
                WAIT_RELEASE: begin
                    if (held_vec == '0) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    press_valid <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

`ifdef KEY_PRESS_COUNT_EN
    // Accepted-event counter, holds at its maximum instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            press_count <= '0;
        end else if (press_valid && press_ready && (press_count != 8'hFF)) begin
            press_count <= press_count + 8'd1;
        end
    end
`endif

endmodule : key_press_capture
